mul_seq: RTL
============

# mul_seq

Sequential shift-add multiplier: the multiply counterpart to the restoring divider in the calculator datapath. It accepts two W-bit operands on a `start` pulse and retires one multiplier bit per clock. After W iteration cycles it presents a 2W-bit product with `valid` asserted. It sits beside the divider behind the PicoVersat-controlled ALU select, with the same start/valid handshake, so the display/result mux treats both units identically.

## Interface
- `W`, default 4: operand width in bits; legal range is 2 to 16.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  operation request, sampled on the rising edge of `clk`.
- `a`  in  W  multiplicand; sampled only on the edge where `start` is 1.
- `b`  in  W  multiplier; sampled only on the edge where `start` is 1.
- `p`  out  2W  product register; meaningful only while `valid`=1.
- `valid`  out  1  result ready; registered and sticky until the next `start`.
- `busy`  out  1  iteration in progress.

## Operation
- **Registers**
  - `acc`: 2W bits; drives `p`.
  - `mcand`: 2W bits; zero-extended `a`, or sign-extended `a` when signed.
  - `mplier`: W bits.
  - `cnt`: ceil(log2 W)+1 bits.
  - State: IDLE, RUN, DONE.
- **Reset** (asynchronous, any state, including mid-operation): state=IDLE, `acc`=0, `cnt`=0, `p`=0, `valid`=0, `busy`=0. The operation in flight is discarded.
- **IDLE**
  - `start`=1: load `mcand` and `mplier`; set `acc`=0 and `cnt`=0; go to RUN.
  - `start`=0: hold.
- **RUN**, one step per edge: if `mplier[cnt]`=1, then `acc` <= `acc` + (`mcand` << `cnt`), truncated to 2W bits. Then `cnt` <= `cnt`+1.
  - The step with `cnt`=W-1 moves to DONE.
- **DONE**
  - Hold `acc`, with `valid`=1.
  - `start`=1 reloads exactly as in IDLE, goes to RUN, and clears `valid` on the same edge.
- **`start` during RUN**: aborts the current operation, reloads the new operands, and restarts with `cnt`=0. No `valid` pulse is produced for the aborted operation.
- **Outputs**
  - `busy` = (state==RUN).
  - `valid` = (state==DONE).
  - `valid` and `busy` are never both 1.
- **Arithmetic**
  - All sums are modulo 2^(2W).
  - Unsigned result is exact: max (2^W-1)^2 < 2^(2W).
  - Inputs `a`/`b` may change freely after the loading edge.

## Timing
- `start` sampled at edge N, so operands are loaded at N.
- Iterations occur at edges N+1 … N+W.
- `busy`=1 from after edge N until after edge N+W.
- `valid`=1 from after edge N+W. With W=4, `valid` rises 4 cycles after the `start` edge.
- Latency is fixed at W cycles, independent of operand values; there is no early exit on zero operands.
- Throughput is one result per W+1 cycles when `start` is asserted in the first DONE cycle.
- `p` may show partial sums while `busy`=1; consumers must qualify it with `valid`.

## Configuration
- Macro `MUL_SEQ_SIGNED_EN`.
- **Defined:** operands and product are two's complement.
  - `mcand` = sign-extend(`a`) to 2W bits.
  - Iterations 0…W-2 add as above.
  - The final iteration (`cnt`=W-1) *subtracts* (`mcand` << (W-1)) when `mplier[W-1]`=1.
  - `p` is the exact signed product. The range includes (-2^(W-1))^2 = 2^(2W-2), which fits in 2W bits.
- **Undefined:** unsigned operation only; no subtract path is synthesized.
- The handshake and latency are identical in both builds.

## Test plan
1. **Reset and basic unsigned multiply.**
   - After reset, check `p`=0, `valid`=0, `busy`=0.
   - Apply `a`=3, `b`=5 with a 1-cycle `start`.
   - Require `busy`=1 for exactly 4 cycles, then `valid`=1 with `p`=0x0F, held stable for 10 idle cycles.
2. **Unsigned corner values.**
   - 15×15 gives `p`=0xE1.
   - 0×9 gives `p`=0x00.
   - 9×1 gives `p`=0x09.
   - Each result must appear exactly 4 cycles after its `start` edge.
3. **Signed build** (`MUL_SEQ_SIGNED_EN`).
   - -1×-1 (0xF, 0xF) gives `p`=0x01.
   - -8×7 (0x8, 0x7) gives `p`=0xC8.
   - -8×-8 gives `p`=0x40.
   - 7×-3 (0x7, 0xD) gives `p`=0xEB.
4. **Restart mid-operation.**
   - Start 15×15; two cycles later, start 2×3.
   - Require no `valid` before 4 cycles after the second `start`, then `p`=0x06.
5. **Reset mid-operation.**
   - Start 15×15; assert `rst` asynchronously between clock edges in the second RUN cycle.
   - Require `p`=0, `valid`=0, `busy`=0 immediately, without waiting for a clock edge.
   - After release, a start of 4×4 yields `p`=0x10.
6. **Back-to-back operations.**
   - Assert `start` (operands 2×7) in the first cycle `valid`=1 after a 5×5 operation.
   - Require `valid` to drop on that edge and the next result to be `p`=0x0E, 4 cycles later.

Source files
------------

// File: rtl/mul_seq.sv
// Shift-add W x W -> 2W multiplier, one multiplier bit retired per clock; `MUL_SEQ_SIGNED_EN selects two's complement.
// Latency: W cycles from the start edge to valid; no early exit on zero operands.
// Backpressure: none; start in RUN aborts and restarts, result held with valid until the next start.
module mul_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p,
  output logic           valid,
  output logic           busy
);

  localparam int IW = $clog2(W);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   addend;
  logic             mbit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign addend = mcand_q << cnt_q;
  assign mbit   = mplier_q[cnt_q[IW-1:0]];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    if (start) begin
      // Same reload from every state; a start during RUN abandons the old operands.
`ifdef MUL_SEQ_SIGNED_EN
      mcand_d = {{W{a[W-1]}}, a};
`else
      mcand_d = {{W{1'b0}}, a};
`endif
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = RUN;
    end else if (state_q == RUN) begin
      if (mbit) begin
`ifdef MUL_SEQ_SIGNED_EN
        // The multiplier MSB carries negative weight in two's complement.
        if (cnt_q == LAST) acc_d = acc_q - addend;
        else               acc_d = acc_q + addend;
`else
        acc_d = acc_q + addend;
`endif
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) state_d = DONE;
    end
  end

  assign p     = acc_q;
  assign valid = (state_q == DONE);
  assign busy  = (state_q == RUN);

endmodule
